// File: rtl/wishbone_classic_gpio_multi_pkg.sv
// rtl/wishbone_classic_gpio_multi_pkg.sv - register map and shared types for the multi-bank GPIO
package wishbone_classic_gpio_multi_pkg;

  localparam logic [2:0] REG_DATA_IN    = 3'd0;
  localparam logic [2:0] REG_DATA_OUT   = 3'd1;
  localparam logic [2:0] REG_TRI        = 3'd2;
  localparam logic [2:0] REG_IRQ_EN     = 3'd3;
  localparam logic [2:0] REG_IRQ_MODE   = 3'd4;
  localparam logic [2:0] REG_IRQ_POL    = 3'd5;
  localparam logic [2:0] REG_IRQ_STATUS = 3'd6;
  localparam logic [2:0] REG_RESERVED   = 3'd7;

  localparam int CHANNEL_STRIDE = 'h20;
  localparam int MAX_CHANNELS   = 4;

  // GCTRL lives at byte 0x80, i.e. word index 0x20 of addr[7:2]
  localparam logic [5:0] GCTRL_WORD       = 6'h20;
  localparam int         GCTRL_IRQ_EN_BIT = 0;

  typedef enum logic {
    ST_IDLE,
    ST_ACK
  } wb_state_e;

  function automatic logic [1:0] addr_chan(input logic [7:0] a);
    return 2'(int'(a) / CHANNEL_STRIDE);
  endfunction

endpackage

// File: rtl/wishbone_classic_gpio_multi_if.sv
// rtl/wishbone_classic_gpio_multi_if.sv - Wishbone classic slave bus bundle
interface wishbone_classic_gpio_multi_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int BUS_WIDTH     = 4
);
  logic                     s_wb_cyc;
  logic                     s_wb_stb;
  logic                     s_wb_we;
  logic [ADDRESS_WIDTH-1:0] s_wb_addr;
  logic [BUS_WIDTH*8-1:0]   s_wb_data_i;
  logic [3:0]               s_wb_sel;
  logic [1:0]               s_wb_bte;
  logic [2:0]               s_wb_cti;
  logic                     s_wb_ack;
  logic [BUS_WIDTH*8-1:0]   s_wb_data_o;
  logic                     s_wb_err;

  modport master (
    output s_wb_cyc, s_wb_stb, s_wb_we, s_wb_addr, s_wb_data_i, s_wb_sel, s_wb_bte, s_wb_cti,
    input  s_wb_ack, s_wb_data_o, s_wb_err
  );

  modport slave (
    input  s_wb_cyc, s_wb_stb, s_wb_we, s_wb_addr, s_wb_data_i, s_wb_sel, s_wb_bte, s_wb_cti,
    output s_wb_ack, s_wb_data_o, s_wb_err
  );
endinterface

// File: rtl/wishbone_classic_gpio_chan.sv
// rtl/wishbone_classic_gpio_chan.sv - one GPIO bank: registers, input synchroniser, interrupt status
module wishbone_classic_gpio_chan
  import wishbone_classic_gpio_multi_pkg::*;
#(
  parameter int GPIO_WIDTH = 32,
  parameter int IRQ_ENABLE = 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  i_we,
  input  logic [2:0]            i_reg_idx,
  input  logic [GPIO_WIDTH-1:0] i_wdata,
  input  logic [GPIO_WIDTH-1:0] i_wmask,
  input  logic [GPIO_WIDTH-1:0] i_pins,
  output logic [GPIO_WIDTH-1:0] o_rdata,
  output logic [GPIO_WIDTH-1:0] o_gpio_o,
  output logic [GPIO_WIDTH-1:0] o_gpio_t,
  output logic                  o_irq_pend
);

  logic [GPIO_WIDTH-1:0] r_out, r_tri, r_en, r_mode, r_pol, r_status;
  logic [GPIO_WIDTH-1:0] r_sync1, r_sync2, r_prev;
  logic [GPIO_WIDTH-1:0] w_edge, w_level, w_set, w_clr;

  function automatic logic [GPIO_WIDTH-1:0] f_merge(input logic [GPIO_WIDTH-1:0] old);
    return (old & ~i_wmask) | (i_wdata & i_wmask);
  endfunction

  // Edge compares the synchronised pin with its one-cycle-old copy
  assign w_edge  = (r_pol & r_sync2 & ~r_prev) | (~r_pol & ~r_sync2 & r_prev);
  assign w_level = ~(r_sync2 ^ r_pol);
  assign w_set   = (r_mode & w_edge) | (~r_mode & w_level);
  assign w_clr   = (i_we && i_reg_idx == REG_IRQ_STATUS) ? (i_wdata & i_wmask) : '0;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_out    <= '0;
      r_tri    <= '1;
      r_en     <= '0;
      r_mode   <= '0;
      r_pol    <= '0;
      r_status <= '0;
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_prev   <= '0;
    end else begin
      r_sync1 <= i_pins;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      if (i_we) begin
        case (i_reg_idx)
          REG_DATA_OUT: r_out <= f_merge(r_out);
          REG_TRI:      r_tri <= f_merge(r_tri);
          REG_IRQ_EN:   if (IRQ_ENABLE != 0) r_en <= f_merge(r_en);
          REG_IRQ_MODE: if (IRQ_ENABLE != 0) r_mode <= f_merge(r_mode);
          REG_IRQ_POL:  if (IRQ_ENABLE != 0) r_pol <= f_merge(r_pol);
          default: ;
        endcase
      end
      // A set in the same cycle as a write-1-to-clear wins
      if (IRQ_ENABLE != 0) r_status <= (r_status & ~w_clr) | w_set;
    end
  end

  always_comb begin
    o_rdata = '0;
    case (i_reg_idx)
      REG_DATA_IN:    o_rdata = r_sync2;
      REG_DATA_OUT:   o_rdata = r_out;
      REG_TRI:        o_rdata = r_tri;
      REG_IRQ_EN:     o_rdata = r_en;
      REG_IRQ_MODE:   o_rdata = r_mode;
      REG_IRQ_POL:    o_rdata = r_pol;
      REG_IRQ_STATUS: o_rdata = r_status;
      REG_RESERVED:   o_rdata = '0;
      default:        o_rdata = '0;
    endcase
  end

  assign o_gpio_o   = r_out;
  assign o_gpio_t   = r_tri;
  assign o_irq_pend = |(r_status & r_en);

endmodule

// File: rtl/wishbone_classic_gpio_multi.sv
// rtl/wishbone_classic_gpio_multi.sv - Wishbone classic slave with up to four interrupting GPIO banks
module wishbone_classic_gpio_multi
  import wishbone_classic_gpio_multi_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int BUS_WIDTH     = 4,
  parameter int GPIO_WIDTH    = 32,
  parameter int GPIO_CHANNELS = 2,
  parameter int IRQ_ENABLE    = 1
) (
  input  logic                                clk,
  input  logic                                rstn,
  wishbone_classic_gpio_multi_if.slave        wb,
  output logic                                irq,
  input  logic [GPIO_CHANNELS*GPIO_WIDTH-1:0] gpio_io_i,
  output logic [GPIO_CHANNELS*GPIO_WIDTH-1:0] gpio_io_o,
  output logic [GPIO_CHANNELS*GPIO_WIDTH-1:0] gpio_io_t
);

  localparam int DW = BUS_WIDTH * 8;

  wb_state_e       r_state;
  logic            r_ack, r_err, r_irq, r_gctrl;
  logic [DW-1:0]   r_data;

  logic            w_req, w_is_chan, w_is_gctrl, w_valid, w_wr;
  logic [1:0]      w_chan;
  logic [2:0]      w_idx;
  logic [DW-1:0]   w_wmask, w_rdata;
  logic            w_unused;

  logic [GPIO_WIDTH-1:0]    w_ch_rdata [GPIO_CHANNELS];
  logic [GPIO_CHANNELS-1:0] w_ch_pend;
  logic [GPIO_CHANNELS-1:0] w_ch_we;

  assign w_req      = wb.s_wb_cyc & wb.s_wb_stb & (r_state == ST_IDLE);
  assign w_chan     = addr_chan(wb.s_wb_addr[7:0]);
  assign w_idx      = wb.s_wb_addr[4:2];
  assign w_is_chan  = ~wb.s_wb_addr[7] && (int'(w_chan) < GPIO_CHANNELS) && (int'(w_chan) < MAX_CHANNELS);
  assign w_is_gctrl = (wb.s_wb_addr[7:2] == GCTRL_WORD);
  assign w_valid    = w_is_chan | w_is_gctrl;
  assign w_wr       = w_req & w_valid & wb.s_wb_we;
  assign w_unused   = ^{wb.s_wb_addr[ADDRESS_WIDTH-1:8], wb.s_wb_addr[1:0], wb.s_wb_bte, wb.s_wb_cti};

  always_comb begin
    w_wmask = '0;
    for (int b = 0; b < BUS_WIDTH; b++) begin
      w_wmask[b*8 +: 8] = (b < 4) ? {8{wb.s_wb_sel[b & 3]}} : 8'h00;
    end
  end

  always_comb begin
    w_ch_we = '0;
    for (int c = 0; c < GPIO_CHANNELS; c++) begin
      w_ch_we[c] = w_wr && w_is_chan && (w_chan == 2'(c));
    end
  end

  for (genvar g = 0; g < GPIO_CHANNELS; g++) begin : g_chan
    wishbone_classic_gpio_chan #(
      .GPIO_WIDTH (GPIO_WIDTH),
      .IRQ_ENABLE (IRQ_ENABLE)
    ) u_chan (
      .clk        (clk),
      .rstn       (rstn),
      .i_we       (w_ch_we[g]),
      .i_reg_idx  (w_idx),
      .i_wdata    (wb.s_wb_data_i[GPIO_WIDTH-1:0]),
      .i_wmask    (w_wmask[GPIO_WIDTH-1:0]),
      .i_pins     (gpio_io_i[g*GPIO_WIDTH +: GPIO_WIDTH]),
      .o_rdata    (w_ch_rdata[g]),
      .o_gpio_o   (gpio_io_o[g*GPIO_WIDTH +: GPIO_WIDTH]),
      .o_gpio_t   (gpio_io_t[g*GPIO_WIDTH +: GPIO_WIDTH]),
      .o_irq_pend (w_ch_pend[g])
    );
  end

  always_comb begin
    w_rdata = '0;
    if (w_is_gctrl) begin
      w_rdata[GCTRL_IRQ_EN_BIT] = r_gctrl;
    end else begin
      for (int c = 0; c < GPIO_CHANNELS; c++) begin
        if (w_is_chan && w_chan == 2'(c)) w_rdata[GPIO_WIDTH-1:0] = w_ch_rdata[c];
      end
    end
  end

  // The ACK state forces one idle cycle so a held strobe completes every 2 cycles
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_data  <= '0;
      r_gctrl <= 1'b0;
      r_irq   <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      r_irq <= (IRQ_ENABLE != 0) && r_gctrl && (|w_ch_pend);
      case (r_state)
        ST_IDLE: begin
          if (w_req) begin
            r_state <= ST_ACK;
            if (w_valid) begin
              r_ack  <= 1'b1;
              r_data <= wb.s_wb_we ? '0 : w_rdata;
              if (IRQ_ENABLE != 0 && w_wr && w_is_gctrl && w_wmask[GCTRL_IRQ_EN_BIT])
                r_gctrl <= wb.s_wb_data_i[GCTRL_IRQ_EN_BIT];
            end else begin
              r_err  <= 1'b1;
              r_data <= '0;
            end
          end
        end
        ST_ACK:  r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign wb.s_wb_ack    = r_ack;
  assign wb.s_wb_err    = r_err;
  assign wb.s_wb_data_o = r_data;
  assign irq            = r_irq;

endmodule
